// File: rtl/capture_fifo_ctrl.sv
// ADC capture buffer: arms on adc_en, waits for a threshold trigger, stores a
// burst of LEN samples in internal RAM, then drains it over a valid/ready link.
module capture_fifo_ctrl #(
   parameter int DW         = 8,
   parameter int AW         = 15,
   parameter int SEL_W      = 4,
   parameter int UNIT_SHIFT = 11
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [DW-1:0]    din,
   input  logic             din_en,
   input  logic             adc_en,
   input  logic [SEL_W-1:0] depth_sel,
   input  logic [1:0]       trig_mode,
   input  logic [DW-1:0]    trig_level,
   input  logic             cont_mode,
   input  logic             tx_rdy,
   output logic [DW-1:0]    tx_data,
   output logic             tx_en,
   output logic [AW:0]      fill_cnt,
   output logic             over,
   output logic             busy,
   output logic             dropped
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARMED   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   localparam logic [1:0] TRIG_IMM  = 2'd0;
   localparam logic [1:0] TRIG_RISE = 2'd1;
   localparam logic [1:0] TRIG_FALL = 2'd2;

   logic [1:0]       state;
   logic             din_en_d;
   logic             stb;
   logic             low_seen;

   logic [SEL_W-1:0] sel_q;
   logic [1:0]       mode_q;
   logic [DW-1:0]    level_q;
   logic             cont_q;

   logic [DW-1:0]    prev;
   logic             prev_vld;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      len;
   logic [AW:0]      issued;
   logic             q_vld;
   logic [DW-1:0]    rd_q;
   logic [DW-1:0]    mem [0:(1<<AW)-1];

   logic             hit, rise, fall;
   logic             wr_en, last_wr;
   logic             take, load_tx, issue, last_take;
   logic             arm, enter_armed;

   assign stb       = din_en & ~din_en_d;
   assign len       = ({{(AW+1-SEL_W){1'b0}}, sel_q} + (AW+1)'(1)) << UNIT_SHIFT;
   assign busy      = (state != S_IDLE);

   assign rise      = prev_vld && (prev <  level_q) && (din >= level_q);
   assign fall      = prev_vld && (prev >= level_q) && (din <  level_q);

   // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      hit = 1'b0;
      case (mode_q)
         TRIG_IMM:  hit = 1'b1;
         TRIG_RISE: hit = rise;
         TRIG_FALL: hit = fall;
         default:   hit = rise | fall;
      endcase
   end

   assign wr_en     = stb && adc_en &&
                      (((state == S_ARMED) && hit) || ((state == S_CAPTURE) && (fill_cnt < len)));
   assign last_wr   = wr_en && ((fill_cnt + (AW+1)'(1)) == len);

   // Two-stage drain pipe: rd_q holds the prefetched word, tx_data the offered one.
   assign take      = tx_en && tx_rdy;
   assign load_tx   = q_vld && (!tx_en || take);
   assign issue     = (state == S_DRAIN) && adc_en && (issued < len) && (!q_vld || load_tx);
   assign last_take = (state == S_DRAIN) && adc_en && take && (fill_cnt == (AW+1)'(1));

   assign arm         = (state == S_IDLE) && adc_en && (cont_mode || low_seen);
   assign enter_armed = arm || (last_take && cont_q);

   // NOTE: the sample RAM and its read register carry no reset; pointers and valid flags guard their contents.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
      if (issue) rd_q <= mem[rd_ptr];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_q   <= '0;
         mode_q  <= '0;
         level_q <= '0;
         cont_q  <= 1'b0;
         dropped <= 1'b0;
      end else begin
         if (enter_armed) begin
            sel_q   <= depth_sel;
            mode_q  <= trig_mode;
            level_q <= trig_level;
            cont_q  <= cont_mode;
            dropped <= 1'b0;
         end else if (stb && ((state == S_DRAIN) || ((state == S_CAPTURE) && (fill_cnt == len)))) begin
            dropped <= 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         din_en_d <= 1'b0;
         low_seen <= 1'b1;
         prev     <= '0;
         prev_vld <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         issued   <= '0;
         q_vld    <= 1'b0;
         fill_cnt <= '0;
         tx_en    <= 1'b0;
         tx_data  <= '0;
         over     <= 1'b0;
      end else begin
         din_en_d <= din_en;
         over     <= 1'b0;
         if (!adc_en) low_seen <= 1'b1;

         if ((state != S_IDLE) && !adc_en) begin
            state    <= S_IDLE;
            prev_vld <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            issued   <= '0;
            q_vld    <= 1'b0;
            fill_cnt <= '0;
            tx_en    <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (arm) begin
                     state    <= S_ARMED;
                     low_seen <= 1'b0;
                  end
               end
               S_ARMED, S_CAPTURE: begin
                  if ((state == S_ARMED) && stb) begin
                     prev     <= din;
                     prev_vld <= 1'b1;
                  end
                  if (wr_en) begin
                     wr_ptr   <= wr_ptr + AW'(1);
                     fill_cnt <= fill_cnt + (AW+1)'(1);
                     state    <= last_wr ? S_DRAIN : S_CAPTURE;
                  end
               end
               default: begin
                  if (issue) begin
                     rd_ptr <= rd_ptr + AW'(1);
                     issued <= issued + (AW+1)'(1);
                     q_vld  <= 1'b1;
                  end else if (load_tx) begin
                     q_vld  <= 1'b0;
                  end
                  if (load_tx) begin
                     tx_data <= rd_q;
                     tx_en   <= 1'b1;
                  end else if (take) begin
                     tx_en   <= 1'b0;
                  end
                  if (take) fill_cnt <= fill_cnt - (AW+1)'(1);
                  if (last_take) begin
                     over     <= 1'b1;
                     tx_en    <= 1'b0;
                     q_vld    <= 1'b0;
                     rd_ptr   <= '0;
                     issued   <= '0;
                     wr_ptr   <= '0;
                     prev_vld <= 1'b0;
                     state    <= cont_q ? S_ARMED : S_IDLE;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_capture_fifo_ctrl.sv
// Randomised bench for capture_fifo_ctrl on a scaled-down buffer (64 words, 16-word units);
// expected drain contents are derived from the trigger rules applied to the strobed samples.
module tb_capture_fifo_ctrl;

   localparam int DW = 8;
   localparam int AW = 6;
   localparam int SEL_W = 2;
   localparam int US = 4;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic [DW-1:0]    din = '0;
   logic             din_en = 1'b0;
   logic             adc_en = 1'b0;
   logic [SEL_W-1:0] depth_sel = '0;
   logic [1:0]       trig_mode = '0;
   logic [DW-1:0]    trig_level = '0;
   logic             cont_mode = 1'b0;
   logic             tx_rdy = 1'b0;
   logic [DW-1:0]    tx_data;
   logic             tx_en;
   logic [AW:0]      fill_cnt;
   logic             over;
   logic             busy;
   logic             dropped;

   capture_fifo_ctrl #(.DW(DW), .AW(AW), .SEL_W(SEL_W), .UNIT_SHIFT(US)) dut (
      .clk(clk), .reset_n(reset_n), .din(din), .din_en(din_en), .adc_en(adc_en),
      .depth_sel(depth_sel), .trig_mode(trig_mode), .trig_level(trig_level),
      .cont_mode(cont_mode), .tx_rdy(tx_rdy), .tx_data(tx_data), .tx_en(tx_en),
      .fill_cnt(fill_cnt), .over(over), .busy(busy), .dropped(dropped)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected drain contents and observation counters
   logic [DW-1:0] exp_q[$];
   int            over_cnt = 0;
   int            xfer_cnt = 0;
   int            txen_cycles = 0;
   int            max_fill = 0;
   bit            hold_vld = 0;
   logic [DW-1:0] hold_data = '0;
   bit            first_seen = 0;
   logic [DW-1:0] first_tx = '0;
   int            rdy_mode = 0;
   int            phase = 0;
   int            dir_samples[4] = '{'h10, 'h70, 'h90, 'hA0};

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: tx_rdy = 1'b1;
         1: tx_rdy = 1'($urandom_range(0, 1));
         default: begin
            tx_rdy = (phase == 0);
            phase = (phase + 1) % 3;
         end
      endcase
   end

   always @(negedge clk) begin
      if (reset_n) begin
         if (hold_vld) check("tx_hold", {55'd0, tx_en, tx_data}, {55'd0, 1'b1, hold_data});
         hold_vld = tx_en && !tx_rdy;
         hold_data = tx_data;
         if (tx_en) txen_cycles++;
         if (int'(fill_cnt) > max_fill) max_fill = int'(fill_cnt);
         if (tx_en && tx_rdy) begin
            xfer_cnt++;
            if (!first_seen) begin
               first_seen = 1;
               first_tx = tx_data;
            end
            if (exp_q.size() == 0) check("tx_unexpected", 1, 0);
            else check("tx_data", tx_data, exp_q.pop_front());
         end
         if (over) begin
            over_cnt++;
            check("over_q_empty", exp_q.size(), 0);
            check("over_fill", fill_cnt, 0);
         end
      end else begin
         hold_vld = 0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [DW-1:0] v);
      din = v;
      din_en = 1'b1;
      repeat ($urandom_range(1, 2)) tick();
      din_en = 1'b0;
      repeat ($urandom_range(1, 2)) tick();
   endtask

   function automatic bit trig_hit(int mode, int lvl, bit have_prev, int prev, int cur);
      bit r = have_prev && (prev < lvl) && (cur >= lvl);
      bit f = have_prev && (prev >= lvl) && (cur < lvl);
      case (mode)
         0: return 1'b1;
         1: return r;
         2: return f;
         default: return r | f;
      endcase
   endfunction

   task automatic arm(input int sel, input int mode, input int lvl, input bit cont, input bit scramble);
      depth_sel = SEL_W'(sel);
      trig_mode = 2'(mode);
      trig_level = DW'(lvl);
      cont_mode = cont;
      adc_en = 1'b1;
      tick();
      if (scramble) begin
         depth_sel = SEL_W'($urandom);
         trig_mode = 2'($urandom);
         trig_level = DW'($urandom);
      end
      tick();
   endtask

   // pattern: 0 random, 1 ramp from base, 2 directed threshold crossing
   task automatic capture(input int sel, input int mode, input int lvl, input int pattern,
                          input int base, input int extra);
      int len = (sel + 1) << US;
      int stored = 0;
      int i = 0;
      int prev = 0;
      bit have_prev = 0;
      int v;
      first_seen = 0;
      while (stored < len && i < 1500) begin
         case (pattern)
            0: v = $urandom_range(0, 255);
            1: v = (base + i) % 256;
            default: v = (i < 4) ? dir_samples[i] : ('hA0 + i - 3);
         endcase
         if (stored > 0 || trig_hit(mode, lvl, have_prev, prev, v)) begin
            exp_q.push_back(v[DW-1:0]);
            stored++;
         end
         strobe(v[DW-1:0]);
         have_prev = 1;
         prev = v;
         i++;
      end
      check("burst_filled", stored, len);
      repeat (extra) strobe(DW'($urandom));
   endtask

   task automatic wait_over(input int budget);
      int start = over_cnt;
      int n = 0;
      while (over_cnt == start && n < budget) begin
         tick();
         n++;
      end
      check("over_pulse", over_cnt - start, 1);
   endtask

   task automatic disarm();
      adc_en = 1'b0;
      tick();
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_en"}, tx_en, 0);
      check({tag, "_tx_data"}, tx_data, 0);
      check({tag, "_fill"}, fill_cnt, 0);
      check({tag, "_over"}, over, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_dropped"}, dropped, 0);
   endtask

   initial begin
      int x0, o0, t0, sel, mode, lvl, extra, n;

      #2 reset_n = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      tick();

      // Immediate trigger, ramp data, single shot
      rdy_mode = 0;
      x0 = xfer_cnt;
      arm(0, 0, 0, 0, 0);
      capture(0, 0, 0, 1, 0, 0);
      wait_over(400);
      check("t1_xfers", xfer_cnt - x0, 16);
      check("t1_busy", busy, 0);
      check("t1_dropped", dropped, 0);
      o0 = over_cnt;
      repeat (4) tick();
      check("t1_no_rearm", {busy, 32'(over_cnt - o0)}, 0);
      disarm();

      // Rising edge through 0x80
      arm(0, 1, 'h80, 0, 0);
      capture(0, 1, 'h80, 2, 0, 0);
      wait_over(400);
      check("t2_first_word", first_tx, 'h90);
      disarm();

      // Drain with tx_rdy high one cycle in three
      rdy_mode = 2;
      arm(1, 0, 0, 0, 0);
      capture(1, 0, 0, 0, 0, 0);
      wait_over(2000);
      check("t3_busy", busy, 0);
      disarm();

      // Strobes during drain are dropped
      rdy_mode = 0;
      arm(0, 0, 0, 0, 0);
      capture(0, 0, 0, 1, 50, 3);
      wait_over(400);
      check("t4_dropped", dropped, 1);
      disarm();

      // Abort mid-capture, then a clean burst
      arm(1, 0, 0, 0, 0);
      check("t4_dropped_cleared", dropped, 0);
      for (int i = 0; i < 10; i++) strobe(DW'(i));
      check("t5_fill_before_abort", fill_cnt, 10);
      adc_en = 1'b0;
      tick();
      check("t5_busy", busy, 0);
      check("t5_fill", fill_cnt, 0);
      check("t5_tx_en", tx_en, 0);
      o0 = over_cnt;
      t0 = txen_cycles;
      repeat (6) tick();
      check("t5_no_over", over_cnt - o0, 0);
      check("t5_no_tx", txen_cycles - t0, 0);
      arm(0, 0, 0, 0, 0);
      capture(0, 0, 0, 1, 100, 0);
      wait_over(400);
      check("t5_busy_after", busy, 0);
      disarm();

      // Continuous mode with full buffer, then reset mid-drain
      max_fill = 0;
      arm(3, 0, 0, 1, 0);
      capture(3, 0, 0, 0, 0, 0);
      wait_over(600);
      check("t6_full", max_fill, 64);
      check("t6_rearmed", busy, 1);
      capture(3, 0, 0, 1, 7, 0);
      wait_over(600);
      check("t6_rearmed2", busy, 1);
      capture(3, 0, 0, 0, 0, 0);
      x0 = xfer_cnt;
      n = 0;
      while (xfer_cnt - x0 < 20 && n < 400) begin
         tick();
         n++;
      end
      check("t6_mid_drain", (xfer_cnt - x0 >= 20), 1);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("t6_reset");
      exp_q.delete();
      adc_en = 1'b0;
      cont_mode = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();

      // Random bursts with config scrambled after arming
      for (int k = 0; k < 6; k++) begin
         rdy_mode = $urandom_range(0, 2);
         sel = $urandom_range(0, 3);
         mode = $urandom_range(0, 3);
         lvl = $urandom_range(32, 224);
         extra = $urandom_range(0, 2);
         arm(sel, mode, lvl, 0, 1);
         check("rnd_dropped_clear", dropped, 0);
         capture(sel, mode, lvl, 0, 0, extra);
         wait_over(3000);
         check("rnd_busy", busy, 0);
         check("rnd_dropped", dropped, (extra > 0));
         disarm();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
